// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges per-stage stall requests into the hold vector, runs the
// multi-cycle execute countdown, flushes/redirects on exceptions and watches for stuck stalls.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
    parameter int unsigned MC_LEN_W      = 6,
    parameter int unsigned WDOG_W        = 16,
    parameter int unsigned STALL_TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_stallreq_i,
    input  logic                id_stallreq_i,
    input  logic                ex_stallreq_i,
    input  logic                mem_stallreq_i,
    input  logic                ex_mc_start_i,
    input  logic [MC_LEN_W-1:0] ex_mc_len_i,
    input  logic                exc_i,
    output logic [5:0]          stall_o,
    output logic                flush_o,
    output logic [31:0]         new_pc_o,
    output logic                mc_done_o,
    output logic                mc_busy_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(STALL_TIMEOUT - 1);
    localparam logic [MC_LEN_W-1:0] LEN_ONE   = MC_LEN_W'(1);

    state_t              r_state;
    logic [MC_LEN_W-1:0] r_mc_cnt;
    logic                r_mc_done;
    logic                r_mc_busy;
    logic [WDOG_W-1:0]   r_wdog;
    logic                r_timeout;

    logic [MC_LEN_W-1:0] w_eff_len;
    logic                w_mc_accept;
    logic [5:0]          w_stall;
    logic                w_flush;
    logic [31:0]         w_new_pc;

    assign w_eff_len   = (ex_mc_len_i == '0) ? LEN_ONE : ex_mc_len_i;
    assign w_mc_accept = ex_mc_start_i && (r_state == ST_IDLE);

    always_comb begin
        w_stall  = '0;
        w_flush  = 1'b0;
        w_new_pc = '0;
        if (exc_i) begin
            w_flush  = 1'b1;
            w_new_pc = EXC_VECTOR;
        end else if (mem_stallreq_i) begin
            w_stall = 6'b011111;
        end else if (ex_stallreq_i || w_mc_accept || (r_state == ST_BUSY)) begin
            w_stall = 6'b001111;
        end else if (id_stallreq_i) begin
            w_stall = 6'b000111;
        end else if (if_stallreq_i) begin
            w_stall = 6'b000011;
        end
    end

    // Combinational outputs are masked so every output reads 0 while reset is held.
    assign stall_o   = rst ? w_stall  : '0;
    assign flush_o   = rst ? w_flush  : 1'b0;
    assign new_pc_o  = rst ? w_new_pc : '0;
    assign mc_done_o = r_mc_done;
    assign mc_busy_o = r_mc_busy;
    assign timeout_o = r_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_mc_cnt  <= '0;
            r_mc_done <= 1'b0;
            r_mc_busy <= 1'b0;
        end else if (exc_i) begin
            r_state   <= ST_IDLE;
            r_mc_cnt  <= '0;
            r_mc_done <= 1'b0;
            r_mc_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_mc_start_i) begin
                        r_mc_busy <= 1'b1;
                        if (w_eff_len == LEN_ONE) begin
                            r_state   <= ST_DONE;
                            r_mc_done <= 1'b1;
                        end else begin
                            r_state  <= ST_BUSY;
                            r_mc_cnt <= w_eff_len - LEN_ONE;
                        end
                    end
                end
                ST_BUSY: begin
                    r_mc_cnt <= r_mc_cnt - LEN_ONE;
                    if (r_mc_cnt == LEN_ONE) begin
                        r_state   <= ST_DONE;
                        r_mc_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // The result stays presented until execute is free to pass it on.
                    if (!w_stall[3]) begin
                        r_state   <= ST_IDLE;
                        r_mc_done <= 1'b0;
                        r_mc_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mc_cnt  <= '0;
                    r_mc_done <= 1'b0;
                    r_mc_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (w_stall[0]) begin
            if (r_wdog != '1) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (r_wdog == WDOG_LAST) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wdog <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected outputs are queued per driven cycle and
// checked against the DUT with immediate assertions.
module tb_pipe_ctrl;

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        done;
        logic        busy;
        logic        tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, id_req, ex_req, mem_req, mc_start, exc;
    logic [5:0]  mc_len;
    logic [5:0]  stall;
    logic        flush, mc_done, mc_busy, tmo;
    logic [31:0] new_pc;

    int   checks = 0;
    int   errors = 0;
    int   m_wdog = 0;
    logic m_to   = 1'b0;
    exp_t sb[$];

    pipe_ctrl #(
        .EXC_VECTOR   (32'h0000_0040),
        .MC_LEN_W     (6),
        .WDOG_W       (16),
        .STALL_TIMEOUT(5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stallreq_i (if_req),
        .id_stallreq_i (id_req),
        .ex_stallreq_i (ex_req),
        .mem_stallreq_i(mem_req),
        .ex_mc_start_i (mc_start),
        .ex_mc_len_i   (mc_len),
        .exc_i         (exc),
        .stall_o       (stall),
        .flush_o       (flush),
        .new_pc_o      (new_pc),
        .mc_done_o     (mc_done),
        .mc_busy_o     (mc_busy),
        .timeout_o     (tmo)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        e = sb.pop_front();
        cmp({e.tag, ".stall"}, {26'd0, stall}, {26'd0, e.stall});
        cmp({e.tag, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
        cmp({e.tag, ".new_pc"}, new_pc, e.pc);
        cmp({e.tag, ".mc_done"}, {31'd0, mc_done}, {31'd0, e.done});
        cmp({e.tag, ".mc_busy"}, {31'd0, mc_busy}, {31'd0, e.busy});
        cmp({e.tag, ".timeout"}, {31'd0, tmo}, {31'd0, e.tmo});
    endtask

    // One clock cycle: drive inputs, queue what that cycle must show, compare, advance the watchdog model.
    task automatic step(input string tag, input logic i_if, input logic i_id, input logic i_ex,
                        input logic i_mem, input logic i_start, input logic [5:0] i_len,
                        input logic i_exc, input logic [5:0] e_stall, input logic e_done,
                        input logic e_busy);
        exp_t e;
        @(negedge clk);
        if_req = i_if; id_req = i_id; ex_req = i_ex; mem_req = i_mem;
        mc_start = i_start; mc_len = i_len; exc = i_exc;
        e.tag   = tag;
        e.stall = e_stall;
        e.flush = i_exc;
        e.pc    = i_exc ? 32'h0000_0040 : 32'h0;
        e.done  = e_done;
        e.busy  = e_busy;
        e.tmo   = m_to;
        sb.push_back(e);
        #2;
        check_outputs();
        if (e_stall[0]) begin
            if (m_wdog == 4) m_to = 1'b1;
            if (m_wdog != 65535) m_wdog++;
        end else begin
            m_wdog = 0;
        end
    endtask

    // Reset lands between clock edges with requests active, so async clearing and output masking are visible.
    task automatic do_reset(input string tag);
        exp_t e;
        @(negedge clk);
        id_req = 1'b1; mem_req = 1'b1; exc = 1'b1; mc_start = 1'b1; mc_len = 6'd3;
        rst = 1'b0;
        m_wdog = 0;
        m_to   = 1'b0;
        e.tag = tag; e.stall = '0; e.flush = 1'b0; e.pc = '0;
        e.done = 1'b0; e.busy = 1'b0; e.tmo = 1'b0;
        sb.push_back(e);
        #2;
        check_outputs();
        @(negedge clk);
        if_req = 0; id_req = 0; ex_req = 0; mem_req = 0; mc_start = 0; mc_len = 0; exc = 0;
        rst = 1'b1;
    endtask

    initial begin
        if_req = 0; id_req = 0; ex_req = 0; mem_req = 0; mc_start = 0; mc_len = 0; exc = 0;
        rst = 1'b0;
        do_reset("reset");

        //     tag        if id ex mem st len   exc  stall      done busy
        step("id0",       0, 1, 0, 0, 0, 6'd0, 0, 6'b000111, 0, 0);
        step("id1",       0, 1, 0, 0, 0, 6'd0, 0, 6'b000111, 0, 0);
        step("id_off",    0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);
        step("prio_id",   1, 1, 0, 0, 0, 6'd0, 0, 6'b000111, 0, 0);
        step("ex_req",    1, 1, 1, 0, 0, 6'd0, 0, 6'b001111, 0, 0);
        step("if_only",   1, 0, 0, 0, 0, 6'd0, 0, 6'b000011, 0, 0);
        step("idle0",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);

        step("l4_T",      0, 0, 0, 0, 1, 6'd4, 0, 6'b001111, 0, 0);
        step("l4_T1",     0, 0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1);
        step("l4_T2",     0, 0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1);
        step("l4_T3",     0, 0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1);
        step("l4_T4",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 1, 1);
        step("l4_T5",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);

        step("mem_T",     0, 0, 0, 0, 1, 6'd4, 0, 6'b001111, 0, 0);
        step("mem_T1",    0, 0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1);
        step("mem_T2",    0, 0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1);
        step("mem_T3",    0, 0, 0, 1, 0, 6'd0, 0, 6'b011111, 0, 1);
        step("mem_T4",    0, 0, 0, 1, 0, 6'd0, 0, 6'b011111, 1, 1);
        step("mem_T5",    0, 0, 0, 1, 0, 6'd0, 0, 6'b011111, 1, 1);
        step("mem_T6",    0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 1, 1);
        step("mem_T7",    0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);
        do_reset("reset_after_mem");

        step("exc_T",     0, 0, 0, 0, 1, 6'd8, 0, 6'b001111, 0, 0);
        step("exc_T1",    0, 0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1);
        step("exc_T2",    0, 0, 0, 1, 0, 6'd0, 1, 6'b000000, 0, 1);
        step("exc_T3",    0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);
        step("exc_T4",    0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);

        step("l0_T",      0, 0, 0, 0, 1, 6'd0, 0, 6'b001111, 0, 0);
        step("l0_T1",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 1, 1);
        step("l0_T2",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);
        step("l1_T",      0, 0, 0, 0, 1, 6'd1, 0, 6'b001111, 0, 0);
        step("l1_T1",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 1, 1);
        step("l1_T2",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);

        step("l3_T",      0, 0, 0, 0, 1, 6'd3, 0, 6'b001111, 0, 0);
        step("l3_ign",    0, 0, 0, 0, 1, 6'd1, 0, 6'b001111, 0, 1);
        step("l3_T2",     0, 0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1);
        step("l3_T3",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 1, 1);
        step("l3_T4",     0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);

        step("abort_T",   0, 0, 0, 0, 1, 6'd8, 0, 6'b001111, 0, 0);
        step("abort_T1",  0, 0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1);
        do_reset("reset_mid_op");
        step("post_abort",0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);

        for (int i = 0; i < 6; i++) begin
            step("wdog_if", 1, 0, 0, 0, 0, 6'd0, 0, 6'b000011, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step("wdog_hold", 0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);
        end
        do_reset("reset_clears_timeout");
        step("final_idle",0, 0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
